// File: rtl/mult_pkg.sv
// Shared types for the sequential shift-add multiplier.
// Sequencer states and counter sizing helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    function automatic int cnt_w(input int w);
        int r;
        r = $clog2(w);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/add_sub_n.sv
// N-bit combinational adder/subtractor.
// Subtraction is done as invert-plus-carry-in; carry out is dropped.
module add_sub_n #(
    parameter int N = 9
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         sub_i,
    output logic [N-1:0] s_o
);

    logic [N-1:0] b_x;

    assign b_x = b_i ^ {N{sub_i}};
    assign s_o = a_i + b_x + N'(sub_i);

endmodule

// File: rtl/seq_mult_unit.sv
// Signed shift-add multiplier: {X,A} accumulator, B multiplier,
// internal multiplicand register and a four-state sequencer.
module seq_mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Clear,
    input  logic             Load,
    input  logic             Start,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] M,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             X,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             x_q, x_d;
    logic [WIDTH-1:0] mreg_q, mreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             last;
    logic [WIDTH:0]   sum;

    assign last = (cnt_q == LAST);

    // The top multiplier bit carries negative weight, so the last step subtracts.
    add_sub_n #(
        .N(WIDTH + 1)
    ) u_add_sub (
        .a_i  ({x_q, a_q}),
        .b_i  ({mreg_q[WIDTH-1], mreg_q}),
        .sub_i(last),
        .s_o  (sum)
    );

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        x_d    = x_q;
        mreg_d = mreg_q;
        cnt_d  = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    a_d    = '0;
                    x_d    = 1'b0;
                    mreg_d = M;
                    cnt_d  = '0;
                end else begin
                    if (Clear) begin
                        a_d = '0;
                        x_d = 1'b0;
                    end
                    if (Load) begin
                        b_d = D;
                    end
                end
            end
            ADD: begin
                if (b_q[0]) begin
                    {x_d, a_d} = sum;
                end
            end
            SHIFT: begin
                a_d = {x_q, a_q[WIDTH-1:1]};
                b_d = {a_q[0], b_q[WIDTH-1:1]};
                if (!last) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_q    <= '0;
            b_q    <= '0;
            x_q    <= 1'b0;
            mreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            x_q    <= x_d;
            mreg_q <= mreg_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Start) begin
                        state_q <= ADD;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                ADD: begin
                    state_q <= SHIFT;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                end
                SHIFT: begin
                    if (last) begin
                        state_q <= HOLD;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ADD;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!Start) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign A    = a_q;
    assign B    = b_q;
    assign X    = x_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed bench for seq_mult_unit at WIDTH=8 and WIDTH=4.
module tb_seq_mult_unit;

    logic       Clk;
    logic       Reset_n;

    logic       clr8, ld8, st8;
    logic [7:0] d8, m8, a8, b8;
    logic       x8, busy8, done8;

    logic       clr4, ld4, st4;
    logic [3:0] d4, m4, a4, b4;
    logic       x4, busy4, done4;

    int n_chk;
    int n_fail;
    int lat;

    seq_mult_unit #(.WIDTH(8)) u8 (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .Clear  (clr8),
        .Load   (ld8),
        .Start  (st8),
        .D      (d8),
        .M      (m8),
        .A      (a8),
        .B      (b8),
        .X      (x8),
        .Busy   (busy8),
        .Done   (done8)
    );

    seq_mult_unit #(.WIDTH(4)) u4 (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .Clear  (clr4),
        .Load   (ld4),
        .Start  (st4),
        .D      (d4),
        .M      (m4),
        .A      (a4),
        .B      (b4),
        .X      (x4),
        .Busy   (busy4),
        .Done   (done4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run8(input string tag, input logic [7:0] d,
                        input logic [7:0] m, input logic [7:0] ea,
                        input logic [7:0] eb, input logic ex);
        @(negedge Clk);
        ld8 = 1'b1; d8 = d;
        @(negedge Clk);
        ld8 = 1'b0; st8 = 1'b1; m8 = m;
        lat = 0;
        @(negedge Clk);
        lat++;
        chk({tag, "_busy"}, 32'(busy8), 32'd1);
        while (!done8 && lat < 40) begin
            @(negedge Clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, 17);
        chk({tag, "_A"}, 32'(a8), 32'(ea));
        chk({tag, "_B"}, 32'(b8), 32'(eb));
        chk({tag, "_X"}, 32'(x8), 32'(ex));
        chk({tag, "_busy_hold"}, 32'(busy8), 32'd0);
        st8 = 1'b0;
        @(negedge Clk);
        chk({tag, "_idle"}, 32'(done8), 32'd0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        Reset_n = 1'b0;
        clr8 = 0; ld8 = 0; st8 = 0; d8 = '0; m8 = '0;
        clr4 = 0; ld4 = 0; st4 = 0; d4 = '0; m4 = '0;
        #12;
        chk("rst_A", 32'(a8), 32'd0);
        chk("rst_B", 32'(b8), 32'd0);
        chk("rst_busy_done", {30'd0, busy8, done8}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        run8("p413", 8'h3B, 8'h07, 8'h01, 8'h9D, 1'b0);
        run8("n413", 8'h3B, 8'hF9, 8'hFE, 8'h63, 1'b1);
        run8("n413sw", 8'hF9, 8'h3B, 8'hFE, 8'h63, 1'b1);
        run8("minneg", 8'h80, 8'h80, 8'h40, 8'h00, 1'b0);
        run8("zero", 8'h00, 8'hA7, 8'h00, 8'h00, 1'b0);

        // WIDTH=4: -8 * 3
        @(negedge Clk);
        ld4 = 1'b1; d4 = 4'h8;
        @(negedge Clk);
        ld4 = 1'b0; st4 = 1'b1; m4 = 4'h3;
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
        end while (!done4 && lat < 30);
        chk("w4_lat", lat, 9);
        chk("w4_A", 32'(a4), 32'hE);
        chk("w4_B", 32'(b4), 32'h8);
        chk("w4_X", 32'(x4), 32'd1);
        st4 = 1'b0;

        // Ignore rules: Clear/Load/M wiggle while busy and in HOLD
        @(negedge Clk);
        ld8 = 1'b1; d8 = 8'h3B;
        @(negedge Clk);
        ld8 = 1'b0; st8 = 1'b1; m8 = 8'h07;
        @(negedge Clk);
        clr8 = 1'b1; ld8 = 1'b1; d8 = 8'h55; m8 = 8'hFF;
        lat = 1;
        while (!done8 && lat < 40) begin
            @(negedge Clk);
            lat++;
        end
        chk("ign_lat", lat, 17);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
        end
        chk("hold_done", 32'(done8), 32'd1);
        chk("hold_busy", 32'(busy8), 32'd0);
        chk("hold_A", 32'(a8), 32'h01);
        chk("hold_B", 32'(b8), 32'h9D);
        clr8 = 1'b0; ld8 = 1'b0;
        st8 = 1'b0;
        @(negedge Clk);
        chk("drop_done", 32'(done8), 32'd0);
        chk("drop_busy", 32'(busy8), 32'd0);
        ld8 = 1'b1; d8 = 8'h55;
        @(negedge Clk);
        ld8 = 1'b0;
        chk("idle_load", 32'(b8), 32'h55);
        clr8 = 1'b1;
        @(negedge Clk);
        clr8 = 1'b0;
        chk("idle_clear", 32'(a8), 32'h00);

        // Async reset mid-operation at cnt=3
        ld8 = 1'b1; d8 = 8'hFF;
        @(negedge Clk);
        ld8 = 1'b0; st8 = 1'b1; m8 = 8'h7F;
        for (int i = 0; i < 7; i++) begin
            @(negedge Clk);
        end
        chk("pre_rst_busy", 32'(busy8), 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_A", 32'(a8), 32'd0);
        chk("arst_B", 32'(b8), 32'd0);
        chk("arst_X", 32'(x8), 32'd0);
        chk("arst_busy", 32'(busy8), 32'd0);
        chk("arst_done", 32'(done8), 32'd0);
        st8 = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        run8("post_rst", 8'h02, 8'h05, 8'h00, 8'h0A, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
